mem_stage: RTL

Pipeline stage directly downstream of EX. It contains the EX/MEM pipeline register, a byte-addressed data memory, branch resolution and the MEM/WB pipeline register. It supplies the MEM-stage ALU value and the WB-stage data that the EX forwarding multiplexers consume, and the branch-taken signal and target used by IF.

---
 rtl/mem_stage_pkg.sv | 52 +++++
 rtl/mem_stage_if.sv | 45 ++++
 rtl/mem_stage_dmem_byte.sv | 27 ++
 rtl/mem_stage.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: funct3 encodings, widths
// and the EX/MEM register layout.
package mem_stage_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int F3_W  = 3;

  localparam logic [F3_W-1:0] LB  = 3'b000;
  localparam logic [F3_W-1:0] LH  = 3'b001;
  localparam logic [F3_W-1:0] LW  = 3'b010;
  localparam logic [F3_W-1:0] LBU = 3'b100;
  localparam logic [F3_W-1:0] LHU = 3'b101;
  localparam logic [F3_W-1:0] SB  = 3'b000;
  localparam logic [F3_W-1:0] SH  = 3'b001;
  localparam logic [F3_W-1:0] SW  = 3'b010;

  localparam logic [F3_W-1:0] BEQ  = 3'b000;
  localparam logic [F3_W-1:0] BNE  = 3'b001;
  localparam logic [F3_W-1:0] BLT  = 3'b100;
  localparam logic [F3_W-1:0] BGE  = 3'b101;
  localparam logic [F3_W-1:0] BLTU = 3'b110;
  localparam logic [F3_W-1:0] BGEU = 3'b111;

  typedef struct packed {
    logic [XLEN-1:0]  alu;
    logic [XLEN-1:0]  store_data;
    logic [XLEN-1:0]  pc_branch;
    logic             zero;
    logic [REG_W-1:0] rd;
    logic [F3_W-1:0]  funct3;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_read;
    logic             mem_write;
    logic             branch;
  } ex_mem_t;

  // Access-size alignment check; size code 11 is reserved and always faults.
  function automatic logic size_misaligned(input logic [F3_W-1:0] f3,
                                           input logic [1:0] addr_lo);
    logic bad;
    case (f3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX-to-MEM bundle plus the forwarding, branch and write-back outputs of
// the MEM stage; master is the upstream side, slave is mem_stage.
interface mem_stage_if;

  logic [31:0] ALU_OUT_EX;
  logic [31:0] REG_DATA2_EX_FINAL;
  logic [31:0] PC_Branch_EX;
  logic        ZERO_EX;
  logic [4:0]  RD_EX;
  logic [2:0]  FUNCT3_EX;
  logic        RegWrite_EX;
  logic        MemtoReg_EX;
  logic        MemRead_EX;
  logic        MemWrite_EX;
  logic        Branch_EX;
  logic        flush_EX;
  logic        hold;

  logic [31:0] ALU_OUT_MEM;
  logic [4:0]  RD_MEM;
  logic        RegWrite_MEM;
  logic        PCSrc_MEM;
  logic [31:0] PC_Branch_MEM;
  logic        misalign_MEM;
  logic [31:0] ALU_DATA_WB;
  logic [4:0]  RD_WB;
  logic        RegWrite_WB;

  modport master (
    output ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX, ZERO_EX, RD_EX,
           FUNCT3_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
           Branch_EX, flush_EX, hold,
    input  ALU_OUT_MEM, RD_MEM, RegWrite_MEM, PCSrc_MEM, PC_Branch_MEM,
           misalign_MEM, ALU_DATA_WB, RD_WB, RegWrite_WB
  );

  modport slave (
    input  ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX, ZERO_EX, RD_EX,
           FUNCT3_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX,
           Branch_EX, flush_EX, hold,
    output ALU_OUT_MEM, RD_MEM, RegWrite_MEM, PCSrc_MEM, PC_Branch_MEM,
           misalign_MEM, ALU_DATA_WB, RD_WB, RegWrite_WB
  );

endinterface

// File: rtl/mem_stage_dmem_byte.sv
// Word-organised data memory with per-byte-lane write enables and an
// asynchronous word read on the same index.
module dmem_byte #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [3:0][7:0] mem [WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[idx][i] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, data memory access with lane
// steering and load extension, branch resolution and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_WORDS = 256,
  parameter int BR_SLT_BIT = 0
) (
  input logic        clk,
  input logic        rst_n,
  mem_stage_if.slave bus
);

  localparam int IDX_W = $clog2(DMEM_WORDS);

  ex_mem_t           exm_d;
  ex_mem_t           exm_q;
  logic [1:0]        addr_lo;
  logic [IDX_W-1:0]  word_idx;
  logic              misalign_raw;
  logic              store_en;
  logic [3:0]        store_be;
  logic [XLEN-1:0]   store_wdata;
  logic [XLEN-1:0]   load_word;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [XLEN-1:0]   load_val;
  logic              br_cond;
  logic [XLEN-1:0]   wb_data_q;
  logic [REG_W-1:0]  rd_wb_q;
  logic              reg_write_wb_q;

  // A flushed instruction keeps its data fields but loses every side effect.
  always_comb begin
    exm_d            = '0;
    exm_d.alu        = bus.ALU_OUT_EX;
    exm_d.store_data = bus.REG_DATA2_EX_FINAL;
    exm_d.pc_branch  = bus.PC_Branch_EX;
    exm_d.zero       = bus.ZERO_EX;
    exm_d.rd         = bus.RD_EX;
    exm_d.funct3     = bus.FUNCT3_EX;
    exm_d.mem_to_reg = bus.MemtoReg_EX;
    exm_d.reg_write  = bus.RegWrite_EX & ~bus.flush_EX;
    exm_d.mem_read   = bus.MemRead_EX  & ~bus.flush_EX;
    exm_d.mem_write  = bus.MemWrite_EX & ~bus.flush_EX;
    exm_d.branch     = bus.Branch_EX   & ~bus.flush_EX;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exm_q <= '0;
    end else if (!bus.hold) begin
      exm_q <= exm_d;
    end
  end

  assign addr_lo      = exm_q.alu[1:0];
  assign word_idx     = exm_q.alu[IDX_W+1:2];
  assign misalign_raw = size_misaligned(exm_q.funct3, addr_lo);

  always_comb begin
    store_be    = 4'b0000;
    store_wdata = exm_q.store_data;
    case (exm_q.funct3)
      SB: begin
        store_be    = 4'b0001 << addr_lo;
        store_wdata = {4{exm_q.store_data[7:0]}};
      end
      SH: begin
        store_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{exm_q.store_data[15:0]}};
      end
      SW:      store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  // Reset is folded in here because the storage itself has no reset.
  assign store_en = exm_q.mem_write & ~bus.hold & rst_n & ~misalign_raw;

  dmem_byte #(
    .WORDS (DMEM_WORDS),
    .IDX_W (IDX_W)
  ) u_dmem (
    .clk   (clk),
    .we    (store_en),
    .be    (store_be),
    .idx   (word_idx),
    .wdata (store_wdata),
    .rdata (load_word)
  );

  assign load_byte = load_word[{addr_lo, 3'b000} +: 8];
  assign load_half = addr_lo[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_val = '0;
    case (exm_q.funct3)
      LB:      load_val = {{24{load_byte[7]}}, load_byte};
      LH:      load_val = {{16{load_half[15]}}, load_half};
      LW:      load_val = load_word;
      LBU:     load_val = {24'd0, load_byte};
      LHU:     load_val = {16'd0, load_half};
      default: load_val = '0;
    endcase
    if (misalign_raw) begin
      load_val = '0;
    end
  end

  always_comb begin
    br_cond = 1'b0;
    case (exm_q.funct3)
      BEQ:         br_cond = exm_q.zero;
      BNE:         br_cond = ~exm_q.zero;
      BLT, BLTU:   br_cond = exm_q.alu[BR_SLT_BIT];
      BGE, BGEU:   br_cond = ~exm_q.alu[BR_SLT_BIT];
      default:     br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_data_q      <= '0;
      rd_wb_q        <= '0;
      reg_write_wb_q <= 1'b0;
    end else if (!bus.hold) begin
      wb_data_q      <= exm_q.mem_to_reg ? load_val : exm_q.alu;
      rd_wb_q        <= exm_q.rd;
      reg_write_wb_q <= exm_q.reg_write;
    end
  end

  assign bus.ALU_OUT_MEM   = exm_q.alu;
  assign bus.RD_MEM        = exm_q.rd;
  assign bus.RegWrite_MEM  = exm_q.reg_write;
  assign bus.PCSrc_MEM     = exm_q.branch & br_cond;
  assign bus.PC_Branch_MEM = exm_q.pc_branch;
  assign bus.misalign_MEM  = misalign_raw & (exm_q.mem_read | exm_q.mem_write);
  assign bus.ALU_DATA_WB   = wb_data_q;
  assign bus.RD_WB         = rd_wb_q;
  assign bus.RegWrite_WB   = reg_write_wb_q;

endmodule
